axilite_mem_s: RTL and testbench

Parametrised AXI4-Lite slave fronting an on-chip word memory; successor to the single-FSM 32-bit/128-word slave. Read and write paths are independent and run concurrently, AW and W may arrive in either order or together, and read latency is configurable. It sits behind the interconnect as a register/scratch memory target and is the standard slave model for the AXI-Lite testbench.

---
 rtl/axilite_pkg.sv | 30 +++
 rtl/axilite_mem_s_if.sv | 46 ++++
 rtl/axilite_mem_ram.sv | 33 +++
 rtl/axilite_mem_s.sv | 182 ++++++++++++++++++
 tb/tb_axilite_mem_s.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axilite_pkg.sv
// Shared types and sizing helpers for the AXI4-Lite word-memory slave.
// Contents: AXI response codes, read-path FSM states, strobe-width and
// byte-offset helpers, read-latency counter width.
package axilite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_WAIT,
      RD_VALID
   } rd_state_t;

   // RD_LAT is at most 15, so four bits always cover the wait count.
   localparam int unsigned RD_CNT_W = 4;

   function automatic int unsigned strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned off_bits(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/axilite_mem_s_if.sv
// AXI4-Lite bus bundle between a master and the word-memory slave.
// Signals: AW (awvalid/awready/awaddr), W (wvalid/wready/wdata[/wstrb]),
// B (bvalid/bready/bresp), AR (arvalid/arready/araddr), R (rvalid/rready/rdata/rresp).
// Build option: AXIL_WSTRB_EN adds the wstrb byte-strobe signal.
interface axilite_mem_s_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
`ifdef AXIL_WSTRB_EN
   logic [DATA_W/8-1:0] wstrb;
`endif
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;

   modport master (
`ifdef AXIL_WSTRB_EN
      output wstrb,
`endif
      output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
`ifdef AXIL_WSTRB_EN
      input  wstrb,
`endif
      input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/axilite_mem_ram.sv
// DEPTH x DATA_W word storage: one byte-enabled write port, one synchronous
// read port. Contents are never reset.
// Ports: clk; we/waddr/wdata/wbe write port; re/raddr read request;
// rdata registered read data, updated only on cycles with re=1.
module axilite_mem_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 128,
   localparam int unsigned IDX_W  = $clog2(DEPTH),
   localparam int unsigned STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wbe,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // A read and write on the same edge returns the pre-write word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axilite_mem_s.sv
// AXI4-Lite slave fronting an on-chip word memory. Independent write and read
// paths; AW and W accepted in either order; configurable read latency.
// Ports: s_axi_aclk clock; s_axi_aresetn async active-low reset;
// s_axi slave modport of axilite_mem_s_if (AW/W/B/AR/R channels).
// Build option: AXIL_WSTRB_EN enables per-byte write strobes; otherwise every
// write updates the full word.
module axilite_mem_s
   import axilite_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 128,
   parameter int unsigned RD_LAT = 2
) (
   input  logic           s_axi_aclk,
   input  logic           s_axi_aresetn,
   axilite_mem_s_if.slave s_axi
);

   localparam int unsigned STRB_W    = strb_w(DATA_W);
   localparam int unsigned OFF_W     = off_bits(DATA_W);
   localparam int unsigned IDX_W     = $clog2(DEPTH);
   localparam int unsigned WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

   // ---------------- write path ----------------
   logic              live_q;
   logic              aw_held_q, w_held_q, bvalid_q;
   resp_t             bresp_q;
   logic [ADDR_W-1:0] awaddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q, wstrb_in;
   logic              aw_hs, w_hs, wr_fire, wr_in_rng;
   logic [ADDR_W-1:0] wr_addr, wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [STRB_W-1:0] wr_strb;

`ifdef AXIL_WSTRB_EN
   assign wstrb_in = s_axi.wstrb;
`else
   assign wstrb_in = '1;
`endif

   // live_q keeps every ready low until the first edge after reset release.
   assign s_axi.awready = live_q && !aw_held_q && !bvalid_q;
   assign s_axi.wready  = live_q && !w_held_q && !bvalid_q;
   assign aw_hs         = s_axi.awvalid && s_axi.awready;
   assign w_hs          = s_axi.wvalid && s_axi.wready;
   assign wr_fire       = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign wr_addr       = aw_held_q ? awaddr_q : s_axi.awaddr;
   assign wr_data       = w_held_q ? wdata_q : s_axi.wdata;
   assign wr_strb       = w_held_q ? wstrb_q : wstrb_in;
   assign wr_idx        = wr_addr >> OFF_W;
   assign wr_in_rng     = wr_idx < ADDR_W'(DEPTH);
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         live_q    <= 1'b0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         live_q <= 1'b1;
         if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
         if (wr_fire) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_in_rng ? OKAY : DECERR;
         end else begin
            if (aw_hs) begin
               aw_held_q <= 1'b1;
               awaddr_q  <= s_axi.awaddr;
            end
            if (w_hs) begin
               w_held_q <= 1'b1;
               wdata_q  <= s_axi.wdata;
               wstrb_q  <= wstrb_in;
            end
         end
      end
   end

   // ---------------- read path ----------------
   rd_state_t           rd_state_q;
   logic [RD_CNT_W-1:0] rd_cnt_q;
   logic [IDX_W-1:0]    ar_idx_q, ram_raddr;
   logic                arready_q, rvalid_q, rd_ok_q;
   resp_t               rresp_q;
   logic [ADDR_W-1:0]   ar_idx;
   logic                ar_hs, ar_in_rng, rd_last_wait, ram_re;
   logic [DATA_W-1:0]   ram_rdata;

   assign ar_idx       = s_axi.araddr >> OFF_W;
   assign ar_in_rng    = ar_idx < ADDR_W'(DEPTH);
   assign ar_hs        = arready_q && s_axi.arvalid;
   assign rd_last_wait = (rd_state_q == RD_WAIT) && (rd_cnt_q == RD_CNT_W'(WAIT_LAST));
   // The RAM is sampled on exactly the edge that enters RD_VALID.
   assign ram_re       = (ar_hs && ar_in_rng && (RD_LAT == 1)) || rd_last_wait;
   assign ram_raddr    = ar_hs ? ar_idx[IDX_W-1:0] : ar_idx_q;

   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   // RAM output holds between reads; rd_ok_q forces 0 after reset and on DECERR.
   assign s_axi.rdata   = rd_ok_q ? ram_rdata : '0;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rd_state_q <= RD_IDLE;
         rd_cnt_q   <= '0;
         ar_idx_q   <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rd_ok_q    <= 1'b0;
         rresp_q    <= OKAY;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  ar_idx_q  <= ar_idx[IDX_W-1:0];
                  rd_cnt_q  <= '0;
                  if (!ar_in_rng) begin
                     rd_state_q <= RD_VALID;
                     rvalid_q   <= 1'b1;
                     rresp_q    <= DECERR;
                     rd_ok_q    <= 1'b0;
                  end else if (RD_LAT == 1) begin
                     rd_state_q <= RD_VALID;
                     rvalid_q   <= 1'b1;
                     rresp_q    <= OKAY;
                     rd_ok_q    <= 1'b1;
                  end else begin
                     rd_state_q <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (rd_last_wait) begin
                  rd_state_q <= RD_VALID;
                  rvalid_q   <= 1'b1;
                  rresp_q    <= OKAY;
                  rd_ok_q    <= 1'b1;
               end else begin
                  rd_cnt_q <= rd_cnt_q + RD_CNT_W'(1);
               end
            end
            RD_VALID: begin
               if (s_axi.rready) begin
                  rd_state_q <= RD_IDLE;
                  rvalid_q   <= 1'b0;
                  rd_ok_q    <= 1'b0;
                  arready_q  <= 1'b1;
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   axilite_mem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (s_axi_aclk),
      .we    (wr_fire && wr_in_rng),
      .waddr (wr_idx[IDX_W-1:0]),
      .wdata (wr_data),
      .wbe   (wr_strb),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_axilite_mem_s.sv
// Self-checking bench for axilite_mem_s: directed scenarios plus randomized
// traffic against a word-array reference model kept in the bench.
module tb_axilite_mem_s;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 128;
   localparam int unsigned RD_LAT = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axilite_mem_s_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   axilite_mem_s #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rstn),
      .s_axi         (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] ref_mem [DEPTH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic in_range(input logic [31:0] addr);
      return (addr >> 2) < DEPTH;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] addr);
      return in_range(addr) ? 2'b00 : 2'b11;
   endfunction

   function automatic logic [31:0] exp_data(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr >> 2;
      return in_range(addr) ? ref_mem[idx[6:0]] : 32'h0;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      logic [31:0] idx;
      idx = addr >> 2;
      if (in_range(addr)) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) ref_mem[idx[6:0]][i*8 +: 8] = data[i*8 +: 8];
         end
      end
   endtask

   // Called and returns at a negedge. Delays are in cycles.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
      logic [1:0] er;
      logic aw_done, w_done, hs_aw, hs_w;
      int n;
      er = exp_resp(addr);
      aw_done = 1'b0;
      w_done = 1'b0;
      for (int c = 0; c < 64 && !(aw_done && w_done); c++) begin
         bus.awvalid = !aw_done && (c >= aw_dly);
         bus.awaddr  = addr;
         bus.wvalid  = !w_done && (c >= w_dly);
         bus.wdata   = data;
`ifdef AXIL_WSTRB_EN
         bus.wstrb   = strb;
`endif
         hs_aw = bus.awvalid && bus.awready;
         hs_w  = bus.wvalid && bus.wready;
         @(negedge clk);
         aw_done = aw_done | hs_aw;
         w_done  = w_done | hs_w;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      chk("wr_handshakes", {aw_done, w_done}, 2'b11);
      if (!(aw_done && w_done)) return;
      n = 1;
      while (!bus.bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b_latency", n, 1);
      for (int i = 0; i < b_dly; i++) begin
         chk("b_hold_valid", bus.bvalid, 1'b1);
         chk("b_hold_resp", bus.bresp, er);
         chk("b_hold_ready", {bus.awready, bus.wready}, 2'b00);
         @(negedge clk);
      end
      chk("bresp", {bus.bvalid, bus.bresp}, {1'b1, er});
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      chk("ready_after_b", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
      model_write(addr, data, strb);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      logic [1:0] er;
      logic [31:0] ed;
      logic done, hs;
      int n, el;
      er = exp_resp(addr);
      ed = exp_data(addr);
      el = in_range(addr) ? int'(RD_LAT) : 1;
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         bus.arvalid = (c >= ar_dly);
         bus.araddr  = addr;
         hs = bus.arvalid && bus.arready;
         @(negedge clk);
         done = hs;
      end
      bus.arvalid = 1'b0;
      chk("ar_handshake", done, 1'b1);
      if (!done) return;
      n = 1;
      while (!bus.rvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("r_latency", n, el);
      for (int i = 0; i < r_dly; i++) begin
         chk("r_hold_valid", bus.rvalid, 1'b1);
         chk("r_hold_data", bus.rdata, ed);
         chk("r_hold_resp", bus.rresp, er);
         chk("r_hold_arready", bus.arready, 1'b0);
         @(negedge clk);
      end
      chk("rdata", bus.rdata, ed);
      chk("rresp", {bus.rvalid, bus.rresp}, {1'b1, er});
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      chk("ready_after_r", {bus.rvalid, bus.arready}, 2'b01);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0] s;
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
      bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
`ifdef AXIL_WSTRB_EN
      bus.wstrb = '0;
`endif
      // Reset state
      #12;
      chk("rst_rdy_vld", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
      chk("rst_resp", {bus.bresp, bus.rresp}, 4'b0);
      chk("rst_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // Fill memory so every in-range word has a known value.
      for (int i = 0; i < int'(DEPTH); i++) axi_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0);

      // W two cycles before AW, then read back at RD_LAT.
      axi_write(32'h08, 32'h1234_5678, 4'hF, 2, 0, 0);
      axi_read(32'h08, 0, 0);
      axi_write(32'h2C, 32'h0BAD_F00D, 4'hF, 0, 3, 0);
      axi_read(32'h2D, 1, 0);

      // Out of range: DECERR, no aliasing onto word 0.
      axi_write(32'(DEPTH * 4), 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      axi_read(32'h0, 0, 0);
      axi_read(32'(DEPTH * 4), 0, 0);
      axi_write(32'hFFFF_FFFC, 32'hCAFE_0000, 4'hF, 1, 0, 0);
      axi_read(32'hFFFF_FFFC, 0, 0);

      // Read and write concurrently on different words.
      fork
         axi_read(32'h04, 0, 0);
         axi_write(32'h0C, 32'hC0FF_EE00, 4'hF, 0, 0, 0);
      join
      axi_read(32'h0C, 0, 0);

      // Write committed on the edge that samples the read returns old data.
      fork
         axi_read(32'h18, 0, 0);
         axi_write(32'h18, 32'h5A5A_1818, 4'hF, 1, 1, 0);
      join
      axi_read(32'h18, 0, 0);

      // Backpressure on B and R.
      axi_write(32'h14, 32'h7777_1414, 4'hF, 0, 0, 5);
      axi_read(32'h14, 0, 5);

`ifdef AXIL_WSTRB_EN
      axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      axi_write(32'h20, 32'h0000_00AB, 4'b0001, 0, 0, 0);
      axi_read(32'h20, 0, 0);
      chk("wstrb_model", ref_mem[8], 32'hFFFF_FFAB);
      axi_write(32'h20, 32'h1111_1111, 4'b0000, 0, 0, 0);
      axi_read(32'h20, 0, 0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         a = $urandom_range(0, int'(DEPTH) * 4 + 63);
         d = $urandom;
`ifdef AXIL_WSTRB_EN
         s = 4'($urandom_range(0, 15));
`else
         s = 4'hF;
`endif
         if ($urandom_range(0, 1) == 1)
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Reset with AW and AR in flight: no response afterwards, memory kept.
      bus.awvalid = 1'b1; bus.awaddr = 32'h30;
      bus.arvalid = 1'b1; bus.araddr = 32'h30;
      chk("mid_rst_ready", {bus.awready, bus.arready}, 2'b11);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.arvalid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_rdy_vld", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_rst_no_resp", {bus.bvalid, bus.rvalid}, 2'b00);
      end
      axi_write(32'h10, 32'hA5A5_0001, 4'hF, 2, 0, 0);
      axi_read(32'h10, 0, 0);
      axi_read(32'h30, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
